// File: rtl/instr_encoder_loader_if.sv
// Request channel of the instruction encoder: decoded control fields plus valid/ready.
// The master drives a request; the slave (encoder) answers with req_ready.
interface instr_encoder_loader_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op_class;
  logic [3:0]  alu_sel;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  modport master (
    output req_valid, op_class, alu_sel, rd, rs1, rs2, imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, op_class, alu_sel, rd, rs1, rs2, imm,
    output req_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Re-encodes decoded control fields into RV32I words, buffers them in a FIFO and
// streams them into IMEM at sequential word addresses from a programmable base.
module instr_encoder_loader #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic                   load_en,
  instr_encoder_loader_if.slave  req,
  output logic                   imem_we,
  output logic [ADDR_W-1:0]      imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   busy,
  output logic                   err,
  output logic [7:0]             err_cnt,
  output logic [15:0]            words_written
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = DEPTH[PtrW:0];

  localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluAnd = 4'd2, AluOr  = 4'd3;
  localparam logic [3:0] AluXor = 4'd4, AluSlt = 4'd5, AluShl = 4'd6, AluShr = 4'd7;
  localparam logic [3:0] AluSgte = 4'd8, AluEq = 4'd9, AluNe = 4'd10;

  localparam logic [2:0] ClsR = 3'd0, ClsI = 3'd1, ClsS = 3'd2;
  localparam logic [2:0] ClsL = 3'd3, ClsB = 3'd4, ClsJ = 3'd5;

  // ---------------- encoder ----------------
  logic [2:0]  f3, b_f3;
  logic [6:0]  f7;
  logic        r_ok, b_ok, legal;
  logic [31:0] word;
  logic        unused_imm_hi;

  assign unused_imm_hi = ^req.imm[31:21];

  always_comb begin
    f3   = 3'b000;
    f7   = 7'b0000000;
    r_ok = 1'b1;
    case (req.alu_sel)
      AluAdd:  f3 = 3'b000;
      AluSub:  begin f3 = 3'b000; f7 = 7'b0100000; end
      AluShl:  f3 = 3'b001;
      AluSlt:  f3 = 3'b010;
      AluXor:  f3 = 3'b100;
      AluShr:  begin f3 = 3'b101; f7 = 7'b0100000; end
      AluOr:   f3 = 3'b110;
      AluAnd:  f3 = 3'b111;
      default: r_ok = 1'b0;
    endcase

    b_f3 = 3'b000;
    b_ok = 1'b1;
    case (req.alu_sel)
      AluSub, AluEq: b_f3 = 3'b000;
      AluNe:         b_f3 = 3'b001;
      AluSlt:        b_f3 = 3'b100;
      AluSgte:       b_f3 = 3'b101;
      default:       b_ok = 1'b0;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    word  = 32'h0;
    case (req.op_class)
      ClsR: begin
        legal = r_ok;
        word  = {f7, req.rs2, req.rs1, f3, req.rd, 7'b0110011};
      end
      ClsI: begin
        legal = r_ok && (req.alu_sel != AluSub);
        // Shift immediates carry only a 5-bit shamt; the upper bits select logical vs arithmetic.
        if (req.alu_sel == AluShl || req.alu_sel == AluShr) begin
          word = {f7, req.imm[4:0], req.rs1, f3, req.rd, 7'b0010011};
        end else begin
          word = {req.imm[11:0], req.rs1, f3, req.rd, 7'b0010011};
        end
      end
      ClsS: begin
        legal = (req.alu_sel == AluAdd);
        word  = {req.imm[11:5], req.rs2, req.rs1, 3'b010, req.imm[4:0], 7'b0100011};
      end
      ClsL: begin
        legal = (req.alu_sel == AluAdd);
        word  = {req.imm[11:0], req.rs1, 3'b010, req.rd, 7'b0000011};
      end
      ClsB: begin
        legal = b_ok && !req.imm[0];
        word  = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, b_f3, req.imm[4:1], req.imm[11],
                 7'b1100011};
      end
      ClsJ: begin
        legal = (req.alu_sel == AluAdd) && !req.imm[0];
        word  = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, 7'b1101111};
      end
      default: legal = 1'b0;
    endcase
  end

  // ---------------- FIFO + drain ----------------
  logic [31:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     cnt_q;
  logic [ADDR_W-1:0] wr_addr_q, imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              imem_we_q, err_q;
  logic [7:0]        err_cnt_q;
  logic [15:0]       words_q;
  logic              full, empty, hs, push, pop, drop;

  assign full          = (cnt_q == FullCnt);
  assign empty         = (cnt_q == '0);
  assign req.req_ready = !full && !load_start;
  assign hs            = req.req_valid && req.req_ready;
  assign push          = hs && legal;
  assign drop          = hs && !legal;
  assign pop           = !empty && load_en;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      wr_addr_q    <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      words_q      <= '0;
    end else if (load_start) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      wr_addr_q    <= base_addr;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      words_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (PtrW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (PtrW+1)'(1);
      imem_we_q <= pop;
      if (pop) begin
        imem_addr_q  <= wr_addr_q;
        imem_wdata_q <= mem_q[rd_ptr_q];
        wr_addr_q    <= wr_addr_q + ADDR_W'(4);
        words_q      <= words_q + 16'd1;
      end
      if (drop) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign imem_we       = imem_we_q;
  assign imem_addr     = imem_addr_q;
  assign imem_wdata    = imem_wdata_q;
  assign busy          = !empty;
  assign err           = err_q;
  assign err_cnt       = err_cnt_q;
  assign words_written = words_q;
endmodule
